frame_buffer_pdp: RTL and testbench

FRAME_BUFFER_PDP -- requirements
Module: frame_buffer_pdp

---
 rtl/frame_buffer_pdp.sv | 199 +++++++++++++++++++
 tb/tb_frame_buffer_pdp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pdp.sv
// frame_buffer_pdp: double-buffered frame store for a scanned LED panel.
// The writer fills the back buffer while the scanner reads the front buffer,
// LANES words per access (one per scan lane). A swap_req from the writer is
// honoured at the next frame_done from the scanner, so a frame never tears.
// Optional build macro FRAME_BUFFER_CLEAR_EN: after each swap the new back
// buffer is zeroed, one pixel per cycle, before the writer may use it again.
module frame_buffer_pdp #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int PIXEL_BITS = 32,
  parameter int LANES      = 2,
  localparam int PIXELS     = WIDTH * HEIGHT,
  localparam int LANE_DEPTH = PIXELS / LANES,
  localparam int WA         = $clog2(PIXELS),
  localparam int RA         = $clog2(LANE_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WA-1:0]               write_addr,
  input  logic [PIXEL_BITS-1:0]       write_data,
  input  logic                        write_en,
  input  logic [RA-1:0]               read_addr,
  input  logic                        read_en,
  output logic [LANES*PIXEL_BITS-1:0] read_data,
  output logic                        read_valid,
  input  logic                        swap_req,
  input  logic                        frame_done,
  output logic                        swap_ack,
  output logic                        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } state_e;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam state_e ST_AFTER_SWAP = ST_CLEAR;
`else
  localparam state_e ST_AFTER_SWAP = ST_IDLE;
`endif

  state_e state_q, state_d;
  logic   front_q, front_d;
  logic   swap_ack_q, swap_ack_d;
  logic   busy_q, busy_d;
  logic   read_valid_q, read_valid_d;
  logic [LANES*PIXEL_BITS-1:0] read_data_q, read_data_d;
  logic   swap_s;

`ifdef FRAME_BUFFER_CLEAR_EN
  logic [WA-1:0] clr_cnt_q, clr_cnt_d;
  logic          swap_lat_q, swap_lat_d;
`endif

  // Unified write port: pixel writer, or the clear sweep when it owns the back buffer
  logic [WA-1:0]         wr_addr_s;
  logic [PIXEL_BITS-1:0] wr_data_s;
  logic                  wr_en_s;
  logic [WA-1:0]         wr_lane_s;
  logic [RA-1:0]         wr_off_s;
  logic [LANES*PIXEL_BITS-1:0] rd_word_s;

  // State, front select and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      front_q      <= 1'b0;
      swap_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
`ifdef FRAME_BUFFER_CLEAR_EN
      clr_cnt_q    <= '0;
      swap_lat_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      swap_ack_q   <= swap_ack_d;
      busy_q       <= busy_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
`ifdef FRAME_BUFFER_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
      swap_lat_q   <= swap_lat_d;
`endif
    end
  end

  // Next state: decide when the swap happens and sequence the clear sweep
  always_comb begin
    state_d = state_q;
    swap_s  = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
    swap_lat_d = swap_lat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (swap_req && frame_done) begin
          swap_s  = 1'b1;
          state_d = ST_AFTER_SWAP;
        end else if (swap_req) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frame_done) begin
          swap_s  = 1'b1;
          state_d = ST_AFTER_SWAP;
        end else begin
          state_d = ST_PENDING;
        end
      end
`ifdef FRAME_BUFFER_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q == WA'(PIXELS - 1)) begin
          // Last pixel cleared: a request seen during the sweep is treated as if made in IDLE
          clr_cnt_d  = '0;
          swap_lat_d = 1'b0;
          if ((swap_lat_q || swap_req) && frame_done) begin
            swap_s  = 1'b1;
            state_d = ST_CLEAR;
          end else if (swap_lat_q || swap_req) begin
            state_d = ST_PENDING;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clr_cnt_d  = clr_cnt_q + WA'(1);
          swap_lat_d = swap_lat_q | swap_req;
          state_d    = ST_CLEAR;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and datapath controls derived from the current decision
  always_comb begin
    front_d      = front_q ^ swap_s;
    swap_ack_d   = swap_s;
    busy_d       = (state_d != ST_IDLE);
    read_valid_d = read_en;
    if (read_en) begin
      read_data_d = rd_word_s;
    end else begin
      read_data_d = read_data_q;
    end
    wr_en_s   = write_en;
    wr_addr_s = write_addr;
    wr_data_s = write_data;
`ifdef FRAME_BUFFER_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_cnt_q;
      wr_data_s = '0;
    end else begin
      wr_en_s   = write_en;
      wr_addr_s = write_addr;
      wr_data_s = write_data;
    end
`endif
  end

  // Upper address bits pick the lane, lower bits the word inside that lane
  assign wr_lane_s = wr_addr_s >> RA;
  assign wr_off_s  = wr_addr_s[RA-1:0];

  // One memory per lane, each holding both buffers: index = {buffer, offset}
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PIXEL_BITS-1:0] mem_q [0:2*LANE_DEPTH-1];
    logic                  wr_hit_s;

    assign wr_hit_s = wr_en_s && (wr_lane_s == WA'(k));

    // Writes always target the back buffer; contents survive reset
    always_ff @(posedge clk) begin
      if (wr_hit_s) begin
        mem_q[{~front_q, wr_off_s}] <= wr_data_s;
      end
    end

    assign rd_word_s[k*PIXEL_BITS +: PIXEL_BITS] = mem_q[{front_q, read_addr}];
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign swap_ack   = swap_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_buffer_pdp.sv
// Scoreboard bench for frame_buffer_pdp: instance A uses default parameters,
// instance B uses a 32x16 panel with 4 lanes. Expected reads and swap_ack
// times are queued at issue and checked by a negedge monitor.
module tb_frame_buffer_pdp;
  localparam int PB    = 32;
  localparam int A_PIX = 2048;
  localparam int A_WA  = 11;
  localparam int A_RA  = 10;
  localparam int B_PIX = 512;
  localparam int B_WA  = 9;
  localparam int B_RA  = 7;
`ifdef FRAME_BUFFER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  logic [A_WA-1:0]   a_write_addr;
  logic [PB-1:0]     a_write_data;
  logic              a_write_en;
  logic [A_RA-1:0]   a_read_addr;
  logic              a_read_en;
  logic [2*PB-1:0]   a_read_data;
  logic              a_read_valid;
  logic              a_swap_req;
  logic              a_frame_done;
  logic              a_swap_ack;
  logic              a_busy;

  logic [B_WA-1:0]   b_write_addr;
  logic [PB-1:0]     b_write_data;
  logic              b_write_en;
  logic [B_RA-1:0]   b_read_addr;
  logic              b_read_en;
  logic [4*PB-1:0]   b_read_data;
  logic              b_read_valid;
  logic              b_swap_req;
  logic              b_frame_done;
  logic              b_swap_ack;
  logic              b_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [2*PB-1:0] a_rq[$];
  logic [4*PB-1:0] b_rq[$];
  int              a_aq[$];
  int              b_aq[$];
  logic [2*PB-1:0] a_exp;
  logic [4*PB-1:0] b_exp;
  int              a_ack_exp;
  int              b_ack_exp;

  frame_buffer_pdp u_a (
    .clk(clk), .reset_n(reset_n),
    .write_addr(a_write_addr), .write_data(a_write_data), .write_en(a_write_en),
    .read_addr(a_read_addr), .read_en(a_read_en),
    .read_data(a_read_data), .read_valid(a_read_valid),
    .swap_req(a_swap_req), .frame_done(a_frame_done),
    .swap_ack(a_swap_ack), .busy(a_busy)
  );

  frame_buffer_pdp #(.WIDTH(32), .HEIGHT(16), .PIXEL_BITS(PB), .LANES(4)) u_b (
    .clk(clk), .reset_n(reset_n),
    .write_addr(b_write_addr), .write_data(b_write_data), .write_en(b_write_en),
    .read_addr(b_read_addr), .read_en(b_read_en),
    .read_data(b_read_data), .read_valid(b_read_valid),
    .swap_req(b_swap_req), .frame_done(b_frame_done),
    .swap_ack(b_swap_ack), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented output must match the head of its queue
  always @(negedge clk) begin
    if (a_read_valid) begin
      checks++;
      if (a_rq.size() == 0) begin
        errors++;
        $display("FAIL a_read unexpected read_valid data=%h", a_read_data);
      end else begin
        a_exp = a_rq.pop_front();
        if (a_read_data !== a_exp) begin
          errors++;
          $display("FAIL a_read got %h expected %h", a_read_data, a_exp);
        end
      end
    end
    if (a_swap_ack) begin
      checks++;
      if (a_aq.size() == 0) begin
        errors++;
        $display("FAIL a_swap_ack unexpected pulse at cycle %0d", cyc);
      end else begin
        a_ack_exp = a_aq.pop_front();
        if (cyc != a_ack_exp) begin
          errors++;
          $display("FAIL a_swap_ack at cycle %0d expected cycle %0d", cyc, a_ack_exp);
        end
      end
    end
    if (b_read_valid) begin
      checks++;
      if (b_rq.size() == 0) begin
        errors++;
        $display("FAIL b_read unexpected read_valid data=%h", b_read_data);
      end else begin
        b_exp = b_rq.pop_front();
        if (b_read_data !== b_exp) begin
          errors++;
          $display("FAIL b_read got %h expected %h", b_read_data, b_exp);
        end
      end
    end
    if (b_swap_ack) begin
      checks++;
      if (b_aq.size() == 0) begin
        errors++;
        $display("FAIL b_swap_ack unexpected pulse at cycle %0d", cyc);
      end else begin
        b_ack_exp = b_aq.pop_front();
        if (cyc != b_ack_exp) begin
          errors++;
          $display("FAIL b_swap_ack at cycle %0d expected cycle %0d", cyc, b_ack_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input int addr, input logic [PB-1:0] d);
    a_write_en = 1'b1; a_write_addr = A_WA'(addr); a_write_data = d;
    tick();
    a_write_en = 1'b0;
  endtask

  task automatic b_write(input int addr, input logic [PB-1:0] d);
    b_write_en = 1'b1; b_write_addr = B_WA'(addr); b_write_data = d;
    tick();
    b_write_en = 1'b0;
  endtask

  task automatic a_read(input int addr, input logic [PB-1:0] l0, input logic [PB-1:0] l1);
    a_read_en = 1'b1; a_read_addr = A_RA'(addr);
    a_rq.push_back({l1, l0});
    tick();
    a_read_en = 1'b0;
  endtask

  // After a swap edge: with clearing built in, busy must last exactly one sweep
  task automatic after_swap(input bit use_b);
    int n;
    int pix;
    n   = 0;
    pix = use_b ? B_PIX : A_PIX;
`ifdef FRAME_BUFFER_CLEAR_EN
    while ((use_b ? b_busy : a_busy) && n < pix + 16) begin
      tick();
      n++;
    end
    chk(use_b ? "b_clear_busy_cycles" : "a_clear_busy_cycles", 128'(n), 128'(pix));
`else
    chk(use_b ? "b_busy_after_swap" : "a_busy_after_swap",
        128'(use_b ? b_busy : a_busy), 128'(0));
`endif
  endtask

  task automatic a_swap_now();
    a_swap_req = 1'b1; a_frame_done = 1'b1;
    a_aq.push_back(cyc + 1);
    tick();
    a_swap_req = 1'b0; a_frame_done = 1'b0;
    after_swap(1'b0);
  endtask

  function automatic logic [PB-1:0] old1(input logic [PB-1:0] v);
    return CLR ? 32'h0 : v;
  endfunction

  initial begin
    reset_n = 1'b0;
    a_write_addr = '0; a_write_data = '0; a_write_en = 1'b0;
    a_read_addr = '0; a_read_en = 1'b0; a_swap_req = 1'b0; a_frame_done = 1'b0;
    b_write_addr = '0; b_write_data = '0; b_write_en = 1'b0;
    b_read_addr = '0; b_read_en = 1'b0; b_swap_req = 1'b0; b_frame_done = 1'b0;
    tick(); tick();
    chk("rst_read_data", 128'(a_read_data), 128'(0));
    chk("rst_read_valid", 128'(a_read_valid), 128'(0));
    chk("rst_swap_ack", 128'(a_swap_ack), 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_b_read_data", 128'(b_read_data), 128'(0));
    reset_n = 1'b1;
    tick();

    // Instance B: 4 lanes, read_addr 0 returns pixels 0,128,256,384
    for (int i = 0; i < B_PIX; i++) b_write(i, PB'(i));
    b_swap_req = 1'b1; b_frame_done = 1'b1;
    b_aq.push_back(cyc + 1);
    tick();
    b_swap_req = 1'b0; b_frame_done = 1'b0;
    after_swap(1'b1);
    b_read_en = 1'b1; b_read_addr = B_RA'(0);
    b_rq.push_back({32'd384, 32'd256, 32'd128, 32'd0});
    tick();
    b_read_addr = B_RA'(5);
    b_rq.push_back({32'd389, 32'd261, 32'd133, 32'd5});
    tick();
    b_read_en = 1'b0;
    tick();

    // Instance A: fill back with value=addr, swap in one cycle, read lanes
    for (int i = 0; i < A_PIX; i++) a_write(i, PB'(i));
    a_swap_now();
    a_read(5, 32'h5, 32'h405);
    a_read(0, 32'h0, 32'h400);
    a_read(1023, 32'h3FF, 32'h7FF);

    // Fill new back, then swap_req alone: old front stays visible while pending
    for (int i = 0; i < A_PIX; i++) a_write(i, PB'(32'h1000 + i));
    a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0;
    chk("pending_busy", 128'(a_busy), 128'(1));
    a_read(5, 32'h5, 32'h405);
    for (int i = 0; i < 9; i++) tick();
    chk("pending_busy_held", 128'(a_busy), 128'(1));
    a_frame_done = 1'b1;
    a_aq.push_back(cyc + 1);
    tick();
    a_frame_done = 1'b0;
    after_swap(1'b0);
    a_read(5, 32'h1005, 32'h1405);

    // Back-buffer write hidden until the swap
    a_write(3, 32'hAA);
    a_read(3, 32'h1003, 32'h1403);
    a_swap_now();
    a_read(3, 32'hAA, old1(32'h403));

    // Reset while pending abandons the swap; frame_done alone is then ignored
    a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0;
    chk("pending_before_reset", 128'(a_busy), 128'(1));
    reset_n = 1'b0;
    #2;
    chk("async_reset_busy", 128'(a_busy), 128'(0));
    tick();
    reset_n = 1'b1;
    tick();
    a_frame_done = 1'b1;
    tick();
    a_frame_done = 1'b0;
    tick();
    chk("idle_frame_done_busy", 128'(a_busy), 128'(0));
    a_read(3, old1(32'h1003), old1(32'h1403));

    // Swap-cycle read sees old front; swap-cycle write lands in old back
    a_swap_req = 1'b1; a_frame_done = 1'b1;
    a_read_en = 1'b1; a_read_addr = A_RA'(7);
    a_write_en = 1'b1; a_write_addr = A_WA'(8); a_write_data = 32'hBB;
    a_rq.push_back({old1(32'h1407), old1(32'h1007)});
    a_aq.push_back(cyc + 1);
    tick();
    a_swap_req = 1'b0; a_frame_done = 1'b0; a_read_en = 1'b0; a_write_en = 1'b0;
    after_swap(1'b0);
    a_read(8, 32'hBB, old1(32'h408));

    for (int i = 0; i < 4; i++) tick();
    chk("a_read_queue_drained", 128'(a_rq.size()), 128'(0));
    chk("a_ack_queue_drained", 128'(a_aq.size()), 128'(0));
    chk("b_read_queue_drained", 128'(b_rq.size()), 128'(0));
    chk("b_ack_queue_drained", 128'(b_aq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
